// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and BCD limits for the MM:SS timers
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] DIG_MAX10 = 4'd9;
    localparam logic [3:0] DIG_MAX6  = 4'd5;

endpackage

// File: rtl/bcd_up_digit.sv
// rtl/bcd_up_digit.sv - one BCD up-counting digit with ripple carry out
module bcd_up_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       carry_in,
    output logic [3:0] q,
    output logic       carry_out
);

    logic [3:0] r_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q <= 4'd0;
        end else if (en && carry_in) begin
            r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
        end
    end

    assign q         = r_q;
    assign carry_out = (r_q == MAX) && carry_in;

endmodule

// File: rtl/stopwatch_up.sv
// rtl/stopwatch_up.sv - MM:SS elapsed-time stopwatch with target minute, lap freeze and ceiling
module stopwatch_up
    import timer_pkg::*;
#(
    parameter int MIN_TENS_MAX    = 9,
    parameter bit SAT_ON_OVERFLOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    input  logic [3:0] I1,
    input  logic [3:0] I0,
    output logic [3:0] D3,
    output logic [3:0] D2,
    output logic [3:0] D1,
    output logic [3:0] D0,
    output logic       LED,
    output logic       ErrorLED,
    output logic       running
);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_target;
    logic [15:0] r_hold;
    logic        r_freeze;
    logic        r_led;
    logic        r_err;
    logic        r_running;

    logic [3:0]  w_q3, w_q2, w_q1, w_q0;
    logic        w_c0, w_c1, w_c2, w_c3;
    logic        w_tick_run;
    logic        w_ceiling;
    logic        w_count_en;
    logic        w_match;
    logic        w_lap_ok;
    logic [3:0]  w_min_tens_next;
    logic [3:0]  w_min_units_next;

    assign w_tick_run = tick && (r_state == RUN);
    // Full carry chain out of the top digit means the count sits at the ceiling.
    assign w_ceiling  = w_c3;
    assign w_count_en = w_tick_run && !(w_ceiling && SAT_ON_OVERFLOW);

    bcd_up_digit #(.MAX(DIG_MAX10)) u_sec_units (
        .clk(clk), .reset(reset), .clr(clear), .en(w_count_en),
        .carry_in(1'b1), .q(w_q0), .carry_out(w_c0)
    );
    bcd_up_digit #(.MAX(DIG_MAX6)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(clear), .en(w_count_en),
        .carry_in(w_c0), .q(w_q1), .carry_out(w_c1)
    );
    bcd_up_digit #(.MAX(DIG_MAX10)) u_min_units (
        .clk(clk), .reset(reset), .clr(clear), .en(w_count_en),
        .carry_in(w_c1), .q(w_q2), .carry_out(w_c2)
    );
    bcd_up_digit #(.MAX(4'(MIN_TENS_MAX))) u_min_tens (
        .clk(clk), .reset(reset), .clr(clear), .en(w_count_en),
        .carry_in(w_c2), .q(w_q3), .carry_out(w_c3)
    );

    // A tick at x:59 lands on (minutes+1):00; compare that against the target.
    assign w_min_units_next = (w_q2 == DIG_MAX10) ? 4'd0 : w_q2 + 4'd1;
    assign w_min_tens_next  = (w_q2 == DIG_MAX10) ? w_q3 + 4'd1 : w_q3;
    assign w_match = w_c1 && !w_ceiling && (r_target != 8'd0) &&
                     ({w_min_tens_next, w_min_units_next} == r_target);

    assign w_lap_ok = lap && ((r_state == RUN) || (r_state == PAUSED));

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start_stop && !r_err) w_state_next = RUN;
                RUN: begin
                    if (w_tick_run && ((w_ceiling && SAT_ON_OVERFLOW) || w_match))
                        w_state_next = DONE;
                    else if (start_stop)
                        w_state_next = PAUSED;
                end
                PAUSED:  if (start_stop) w_state_next = RUN;
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_target  <= 8'd0;
            r_hold    <= 16'd0;
            r_freeze  <= 1'b0;
            r_led     <= 1'b0;
            r_err     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_led     <= (w_state_next == DONE);
            r_running <= (w_state_next == RUN);
            r_err     <= (I1 > DIG_MAX10) || (I0 > DIG_MAX10);
            if ((r_state == IDLE) && (w_state_next == RUN))
                r_target <= {I1, I0};
            if (clear || (w_state_next == DONE)) begin
                r_freeze <= 1'b0;
            end else if (w_lap_ok) begin
                r_freeze <= !r_freeze;
                if (!r_freeze)
                    r_hold <= {w_q3, w_q2, w_q1, w_q0};
            end
        end
    end

    assign {D3, D2, D1, D0} = r_freeze ? r_hold : {w_q3, w_q2, w_q1, w_q0};
    assign LED      = r_led;
    assign ErrorLED = r_err;
    assign running  = r_running;

endmodule

// File: tb/tb_stopwatch_up.sv
// tb/tb_stopwatch_up.sv - self-checking bench for stopwatch_up, saturating and wrapping builds
module tb_stopwatch_up;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
    localparam int CEIL_S = 9 * 600 + 599;

    logic       clk = 1'b0;
    logic       reset = 1'b0, tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [3:0] I1 = 4'd0, I0 = 4'd0;
    logic [3:0] a_d3, a_d2, a_d1, a_d0, b_d3, b_d2, b_d1, b_d0;
    logic       a_led, a_err, a_run, b_led, b_err, b_run;

    int checks = 0;
    int errors = 0;

    int m_st[2], m_secs[2], m_tgt[2], m_hold[2];
    bit m_frz[2], m_err[2];

    typedef struct {
        logic t, s, c, l;
        logic [3:0] i1, i0;
        logic [15:0] d;
        logic led, err, run;
    } vec_t;
    vec_t tab[14];

    logic rt, rs, rc, rl, rr;

    stopwatch_up #(.MIN_TENS_MAX(9), .SAT_ON_OVERFLOW(1'b1)) u_sat (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
        .lap(lap), .I1(I1), .I0(I0), .D3(a_d3), .D2(a_d2), .D1(a_d1), .D0(a_d0),
        .LED(a_led), .ErrorLED(a_err), .running(a_run)
    );
    stopwatch_up #(.MIN_TENS_MAX(9), .SAT_ON_OVERFLOW(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
        .lap(lap), .I1(I1), .I0(I0), .D3(b_d3), .D2(b_d2), .D1(b_d1), .D0(b_d0),
        .LED(b_led), .ErrorLED(b_err), .running(b_run)
    );

    always #5 clk = ~clk;

    // Reference: elapsed time kept as plain seconds, display derived by division.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_st[k] = S_IDLE; m_secs[k] = 0; m_tgt[k] = 0;
                m_frz[k] = 0; m_hold[k] = 0; m_err[k] = 0;
            end else begin
                if (clear) begin
                    m_st[k] = S_IDLE; m_secs[k] = 0; m_frz[k] = 0;
                end else if (m_st[k] == S_IDLE) begin
                    if (start_stop && !m_err[k]) begin
                        m_tgt[k] = I1 * 10 + I0;
                        m_st[k] = S_RUN;
                    end
                end else if (m_st[k] == S_RUN) begin
                    if (lap) begin
                        if (!m_frz[k]) m_hold[k] = m_secs[k];
                        m_frz[k] = !m_frz[k];
                    end
                    if (tick) begin
                        if (m_secs[k] == CEIL_S) begin
                            if (k == 0) m_st[k] = S_DONE;
                            else m_secs[k] = 0;
                        end else begin
                            m_secs[k] = m_secs[k] + 1;
                            if (m_tgt[k] != 0 && m_secs[k] == m_tgt[k] * 60) m_st[k] = S_DONE;
                        end
                    end
                    if (m_st[k] == S_DONE) m_frz[k] = 0;
                    else if (start_stop) m_st[k] = S_PAUSED;
                end else if (m_st[k] == S_PAUSED) begin
                    if (lap) begin
                        if (!m_frz[k]) m_hold[k] = m_secs[k];
                        m_frz[k] = !m_frz[k];
                    end
                    if (start_stop) m_st[k] = S_RUN;
                end
                m_err[k] = (I1 > 9) || (I0 > 9);
            end
        end
    endtask

    function automatic logic [18:0] exp_vec(input int k);
        int s, m;
        s = m_frz[k] ? m_hold[k] : m_secs[k];
        m = s / 60;
        return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10),
                m_st[k] == S_DONE, m_err[k], m_st[k] == S_RUN};
    endfunction

    function automatic logic [18:0] dut_vec(input int k);
        if (k == 0) return {a_d3, a_d2, a_d1, a_d0, a_led, a_err, a_run};
        return {b_d3, b_d2, b_d1, b_d0, b_led, b_err, b_run};
    endfunction

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL model dut%0d t=%0t got=%h exp=%h", k, $time, dut_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic expect_out(input string name, input int k, input logic [15:0] d,
                              input logic led, input logic err, input logic run);
        checks++;
        if (dut_vec(k) !== {d, led, err, run}) begin
            errors++;
            $display("FAIL %s dut%0d got=%h exp=%h", name, k, dut_vec(k), {d, led, err, run});
        end
    endtask

    task automatic expect_both(input string name, input logic [15:0] d,
                               input logic led, input logic err, input logic run);
        expect_out(name, 0, d, led, err, run);
        expect_out(name, 1, d, led, err, run);
    endtask

    task automatic cyc(input logic t, input logic s, input logic c, input logic l, input logic r);
        tick = t; start_stop = s; clear = c; lap = l; reset = r;
        model_step();
        @(posedge clk);
        @(negedge clk);
        tick = 0; start_stop = 0; clear = 0; lap = 0; reset = 0;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        tab[0]  = '{0, 1, 0, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 1};
        tab[1]  = '{1, 0, 0, 0, 4'd0, 4'd0, 16'h0001, 0, 0, 1};
        tab[2]  = '{1, 0, 0, 0, 4'd0, 4'd0, 16'h0002, 0, 0, 1};
        tab[3]  = '{1, 1, 0, 0, 4'd0, 4'd0, 16'h0003, 0, 0, 0};
        tab[4]  = '{1, 0, 0, 0, 4'd0, 4'd0, 16'h0003, 0, 0, 0};
        tab[5]  = '{0, 1, 0, 0, 4'd0, 4'd0, 16'h0003, 0, 0, 1};
        tab[6]  = '{0, 0, 0, 1, 4'd0, 4'd0, 16'h0003, 0, 0, 1};
        tab[7]  = '{1, 0, 0, 0, 4'd0, 4'd0, 16'h0003, 0, 0, 1};
        tab[8]  = '{1, 0, 0, 0, 4'd0, 4'd0, 16'h0003, 0, 0, 1};
        tab[9]  = '{0, 0, 0, 1, 4'd0, 4'd0, 16'h0005, 0, 0, 1};
        tab[10] = '{0, 0, 0, 0, 4'd0, 4'hA, 16'h0005, 0, 1, 1};
        tab[11] = '{1, 0, 0, 0, 4'd0, 4'd0, 16'h0006, 0, 0, 1};
        tab[12] = '{0, 0, 1, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 0};
        tab[13] = '{0, 0, 0, 1, 4'd0, 4'd0, 16'h0000, 0, 0, 0};

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        expect_both("reset", 16'h0000, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            I1 = tab[i].i1;
            I0 = tab[i].i0;
            cyc(tab[i].t, tab[i].s, tab[i].c, tab[i].l, 0);
            expect_both($sformatf("table%0d", i), tab[i].d, tab[i].led, tab[i].err, tab[i].run);
        end

        I1 = 0; I0 = 0;
        cyc(0, 1, 0, 0, 0);
        ticks(75);
        expect_both("basic", 16'h0115, 0, 0, 1);
        ticks(524);
        expect_both("pre_carry", 16'h0959, 0, 0, 1);
        ticks(1);
        expect_both("minute_carry", 16'h1000, 0, 0, 1);
        ticks(5399);
        expect_both("pre_ceiling", 16'h9959, 0, 0, 1);
        ticks(1);
        expect_out("ceiling_sat", 0, 16'h9959, 1, 0, 0);
        expect_out("ceiling_wrap", 1, 16'h0000, 0, 0, 1);
        ticks(1);
        expect_out("done_hold", 0, 16'h9959, 1, 0, 0);

        cyc(0, 0, 1, 0, 0);
        I0 = 4'd2;
        cyc(0, 1, 0, 0, 0);
        ticks(120);
        expect_both("target", 16'h0200, 1, 0, 0);
        ticks(1);
        expect_both("target_hold", 16'h0200, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        expect_both("target_clear", 16'h0000, 0, 0, 0);

        I0 = 4'd0;
        cyc(0, 1, 0, 0, 0);
        ticks(5);
        cyc(1, 1, 0, 0, 0);
        expect_both("tick_and_pause", 16'h0006, 0, 0, 0);
        ticks(3);
        expect_both("paused_ignore", 16'h0006, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        expect_both("resume", 16'h0006, 0, 0, 1);

        ticks(4);
        cyc(0, 0, 0, 1, 0);
        ticks(5);
        expect_both("lap_frozen", 16'h0010, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        expect_both("lap_release", 16'h0015, 0, 0, 1);

        cyc(0, 0, 1, 0, 0);
        I0 = 4'hA;
        cyc(0, 0, 0, 0, 0);
        expect_both("error_set", 16'h0000, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        expect_both("error_blocks_start", 16'h0000, 0, 1, 0);
        I0 = 4'd3;
        cyc(0, 0, 0, 0, 0);
        expect_both("error_clear", 16'h0000, 0, 0, 0);

        I0 = 4'd0;
        cyc(0, 1, 0, 0, 0);
        ticks(5);
        expect_both("pre_reset", 16'h0005, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        expect_both("reset_midrun", 16'h0000, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 499) == 0);
            rt = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 19) == 0);
            rc = ($urandom_range(0, 199) == 0);
            rl = ($urandom_range(0, 29) == 0);
            if (rr) begin
                I1 = 4'd0;
                I0 = 4'($urandom_range(0, 3));
            end else if (!rs && $urandom_range(0, 15) == 0) begin
                I1 = ($urandom_range(0, 9) == 0) ? 4'hB : 4'd0;
                I0 = ($urandom_range(0, 7) == 0) ? 4'hC : 4'($urandom_range(0, 3));
            end
            cyc(rt, rs, rc, rl, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_up.md
Name: stopwatch_up

Overview:
- Elapsed-time stopwatch that counts MM:SS up from 00:00. It is the up-counting counterpart of the board's MM:SS countdown timer.
- Advances on the shared 1 Hz clock-enable pulse and drives the same four BCD digits into the existing DISP7SEG multiplexer.
- Latches an optional minute target from the switches. Raises LED when the target is reached and ErrorLED on an invalid switch setting.

Parameters:
- MIN_TENS_MAX, 9, highest minutes-tens digit; the count ceiling is MIN_TENS_MAX9:59.
- SAT_ON_OVERFLOW, 1, 1 = saturate at the ceiling and enter DONE; 0 = wrap to 00:00 and stay in RUN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; one clock domain only.
- tick  input  1  1 Hz clock-enable pulse, one clk cycle wide.
- start_stop  input  1  single-cycle pulse; starts, pauses or resumes the count.
- clear  input  1  single-cycle pulse; zeroes the count and returns to IDLE.
- lap  input  1  single-cycle pulse; toggles the display freeze.
- I1  input  4  target minutes tens, BCD.
- I0  input  4  target minutes units, BCD.
- D3  output  4  displayed minutes tens.
- D2  output  4  displayed minutes units.
- D1  output  4  displayed seconds tens.
- D0  output  4  displayed seconds units.
- LED  output  1  target reached or ceiling reached (DONE).
- ErrorLED  output  1  invalid target digit.
- running  output  1  high while in RUN.

Behaviour:
- Reset (synchronous, highest priority):
  - state = IDLE.
  - Count and D3..D0 = 0, target = 0.
  - LED = 0, ErrorLED = 0, running = 0, freeze = 0.
- All outputs are registered. Digits change one cycle after the qualifying tick.
- States:
  - IDLE: count = 00:00. start_stop latches target = {I1,I0} and goes to RUN, unless ErrorLED = 1, in which case it stays in IDLE.
  - RUN: each tick increments the count. start_stop goes to PAUSED.
  - PAUSED: tick is ignored. start_stop goes to RUN; the target is not re-latched.
  - DONE: count is held and LED = 1. Only clear or reset leave DONE.
- clear in any state: count = 0, freeze = 0, LED = 0, next state = IDLE.
- Priority: reset > clear > start_stop.
- Increment chain:
  - D0 counts mod 10.
  - D1 counts mod 6 and advances on D0 = 9.
  - D2 counts mod 10 and advances on 5:9 (D1 = 5, D0 = 9).
  - D3 advances on 9:59 (D2 = 9, D1 = 5, D0 = 9).
  - All carries are resolved in the same cycle.
- Ceiling: a tick at MIN_TENS_MAX9:59.
  - SAT_ON_OVERFLOW = 1: count holds at the ceiling, go to DONE, LED = 1.
  - SAT_ON_OVERFLOW = 0: count becomes 00:00 and stays in RUN.
- Target match:
  - When a tick produces count == target:00 with target != 00: go to DONE and assert LED in the same cycle as the digit update.
  - Target 00 disables matching.
- Simultaneous tick and start_stop in RUN: the tick is counted first, then the state goes to PAUSED.
- Simultaneous tick and start_stop in PAUSED: the tick is not counted, then the state goes to RUN.
- ErrorLED:
  - Registered each cycle: ErrorLED = (I1 > 9) or (I0 > 9).
  - This is the live switch check; it does not depend on the latched target.
  - It does not affect RUN, PAUSED or DONE already in progress.
- Lap (freeze):
  - In RUN or PAUSED, lap toggles freeze.
  - While freeze = 1, D3..D0 hold their last value and the internal count keeps advancing.
  - On release, D3..D0 show the live count on the next cycle.
  - Entering DONE forces freeze = 0 so the final time is shown.
  - lap in IDLE or DONE is ignored.
- running = 1 exactly when state is RUN.

Decomposition:
- Shared package (timer_pkg):
  - state encoding: IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3.
  - BCD constants: DIG_MAX10 = 9, DIG_MAX6 = 5.
- One natural sub-module, bcd_up_digit:
  - Parameter MAX.
  - Inputs clk, reset, clr, en, carry_in. Outputs q[3:0] and carry_out (asserted when q == MAX && carry_in).
  - Instantiated four times, with MAX = 9, 5, 9 and MIN_TENS_MAX.

Test Plan:
- Basic count: reset, start_stop with I1 = 0, I0 = 0, then 75 ticks -> D = 01:15, running = 1, LED = 0.
- Minute carry: from 09:59, 1 tick -> 10:00 on the next clk.
- Ceiling, SAT_ON_OVERFLOW = 1: from 99:59, 1 tick -> 99:59 held, LED = 1, state DONE.
- Ceiling, SAT_ON_OVERFLOW = 0: from 99:59, 1 tick -> 00:00, still RUN.
- Target: I1 = 0, I0 = 2, start, 120 ticks -> 02:00, LED = 1. A further tick leaves 02:00 unchanged. clear -> 00:00, LED = 0, IDLE.
- Pause and simultaneous events: at 00:05 in RUN, assert tick and start_stop in the same cycle -> 00:06, PAUSED. Then 3 ticks -> still 00:06. Then start_stop -> RUN.
- Lap: at 00:10, lap, then 5 ticks -> D shows 00:10. lap again -> 00:15 on the next clk.
- Error: I0 = 4'hA -> ErrorLED = 1 next cycle; start_stop in IDLE stays in IDLE. I0 = 3 -> ErrorLED = 0.
- Reset mid-run: reset while running at 00:05 -> all outputs 0, IDLE on the next clk.
